// File: rtl/indication_heard_queue_if.sv
// Method-call channel for a two-argument heard(meth, v) call: the caller raises
// heard__ENA with arguments, and the call fires in any cycle where heard__ENA && heard__RDY.
interface indication_heard_queue_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  heard__ENA;
    logic                  heard__RDY;
    logic [DATA_WIDTH-1:0] meth;
    logic [DATA_WIDTH-1:0] v;

    // The master issues calls, and the slave grants them with heard__RDY.
    modport master (
        output heard__ENA,
        output meth,
        output v,
        input  heard__RDY
    );

    modport slave (
        input  heard__ENA,
        input  meth,
        input  v,
        output heard__RDY
    );
endinterface

// File: rtl/indication_heard_queue.sv
// DEPTH-entry FIFO between a heard() indication producer and a back-pressuring
// consumer, with occupancy and saturating refused-call statistics.
module indication_heard_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int DROP_WIDTH = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    indication_heard_queue_if.slave    indication,
    indication_heard_queue_if.master   out,
    output logic [$clog2(DEPTH):0]     count,
    output logic [DROP_WIDTH-1:0]      drop_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [2*DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]           wp;
    logic [PW-1:0]           rp;
    logic                    rdy;
    logic                    nonempty;
    logic                    enq;
    logic                    deq;

    // Both handshake flags depend on registered occupancy only, so a dequeue
    // cannot open the input in the same cycle.
    assign rdy      = (count != FULL);
    assign nonempty = (count != '0);
    assign enq      = indication.heard__ENA && rdy;
    assign deq      = nonempty && out.heard__RDY;

    assign indication.heard__RDY = rdy;
    assign out.heard__ENA        = nonempty;
    assign out.meth = nonempty ? mem[rp][2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    assign out.v    = nonempty ? mem[rp][DATA_WIDTH-1:0]            : '0;

    always_ff @(posedge CLK) begin
        if (!RST && enq) begin
            mem[wp] <= {indication.meth, indication.v};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wp         <= '0;
            rp         <= '0;
            count      <= '0;
            drop_count <= '0;
        end else begin
            if (enq) begin
                wp <= wp + PW'(1);
            end
            if (deq) begin
                rp <= rp + PW'(1);
            end
            if (enq && !deq) begin
                count <= count + CW'(1);
            end else if (deq && !enq) begin
                count <= count - CW'(1);
            end
            if (indication.heard__ENA && !rdy && (drop_count != '1)) begin
                drop_count <= drop_count + DROP_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_indication_heard_queue.sv
// Directed testbench for indication_heard_queue with DEPTH=4 and 32-bit arguments.
module tb_indication_heard_queue;
    logic        clk;
    logic        rst;
    logic [2:0]  count;
    logic [7:0]  drop_count;
    int          n_cmp;
    int          n_fail;

    indication_heard_queue_if #(.DATA_WIDTH(32)) ind_if ();
    indication_heard_queue_if #(.DATA_WIDTH(32)) out_if ();

    indication_heard_queue #(
        .DATA_WIDTH(32),
        .DEPTH(4),
        .DROP_WIDTH(8)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .indication(ind_if),
        .out(out_if),
        .count(count),
        .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are checked 1 time unit after the rising edge, where they hold the state just committed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ind_if.heard__ENA = 1'b0;
        ind_if.meth       = '0;
        ind_if.v          = '0;
        out_if.heard__RDY = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (ind_if.heard__RDY !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b want 1", ind_if.heard__RDY); end
        n_cmp++; if (out_if.heard__ENA !== 1'b0) begin n_fail++; $display("FAIL reset_ena: got %b want 0", out_if.heard__ENA); end
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
        n_cmp++; if (out_if.meth !== 32'h0) begin n_fail++; $display("FAIL reset_meth: got %h want 0", out_if.meth); end
        n_cmp++; if (out_if.v !== 32'h0) begin n_fail++; $display("FAIL reset_v: got %h want 0", out_if.v); end
    endtask

    task automatic test_single();
        ind_if.heard__ENA = 1'b1;
        ind_if.meth       = 32'h11;
        ind_if.v          = 32'hAA;
        n_cmp++; if (out_if.heard__ENA !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %b want 0", out_if.heard__ENA); end
        tick();
        ind_if.heard__ENA = 1'b0;
        n_cmp++; if (out_if.heard__ENA !== 1'b1) begin n_fail++; $display("FAIL single_ena: got %b want 1", out_if.heard__ENA); end
        n_cmp++; if (out_if.meth !== 32'h11) begin n_fail++; $display("FAIL single_meth: got %h want 11", out_if.meth); end
        n_cmp++; if (out_if.v !== 32'hAA) begin n_fail++; $display("FAIL single_v: got %h want aa", out_if.v); end
        n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", count); end
        out_if.heard__RDY = 1'b1;
        tick();
        out_if.heard__RDY = 1'b0;
        n_cmp++; if (out_if.heard__ENA !== 1'b0) begin n_fail++; $display("FAIL single_drain_ena: got %b want 0", out_if.heard__ENA); end
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_drain_count: got %0d want 0", count); end
        n_cmp++; if (out_if.meth !== 32'h0) begin n_fail++; $display("FAIL single_empty_meth: got %h want 0", out_if.meth); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 4; i++) begin
            ind_if.heard__ENA = 1'b1;
            ind_if.meth       = i;
            ind_if.v          = 32'h100 + i;
            tick();
        end
        n_cmp++; if (ind_if.heard__RDY !== 1'b0) begin n_fail++; $display("FAIL fill_rdy: got %b want 0", ind_if.heard__RDY); end
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", count); end
        for (int i = 0; i < 3; i++) begin
            ind_if.meth = 32'h99;
            ind_if.v    = 32'h999;
            tick();
        end
        ind_if.heard__ENA = 1'b0;
        n_cmp++; if (drop_count !== 8'd3) begin n_fail++; $display("FAIL overflow_drop: got %0d want 3", drop_count); end
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL overflow_count: got %0d want 4", count); end
        out_if.heard__RDY = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_cmp++; if (out_if.meth !== 32'(i)) begin n_fail++; $display("FAIL drain_meth[%0d]: got %h want %h", i, out_if.meth, i); end
            n_cmp++; if (out_if.v !== 32'h100 + 32'(i)) begin n_fail++; $display("FAIL drain_v[%0d]: got %h want %h", i, out_if.v, 32'h100 + i); end
            tick();
        end
        out_if.heard__RDY = 1'b0;
        n_cmp++; if (out_if.heard__ENA !== 1'b0) begin n_fail++; $display("FAIL drain_empty_ena: got %b want 0", out_if.heard__ENA); end
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_empty_count: got %0d want 0", count); end
    endtask

    task automatic test_full_deq();
        for (int i = 1; i <= 4; i++) begin
            ind_if.heard__ENA = 1'b1;
            ind_if.meth       = 32'h20 + i;
            ind_if.v          = 32'h200 + i;
            tick();
        end
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL fulldeq_count_pre: got %0d want 4", count); end
        ind_if.meth       = 32'h55;
        ind_if.v          = 32'h555;
        out_if.heard__RDY = 1'b1;
        n_cmp++; if (ind_if.heard__RDY !== 1'b0) begin n_fail++; $display("FAIL fulldeq_rdy_same: got %b want 0", ind_if.heard__RDY); end
        tick();
        ind_if.heard__ENA = 1'b0;
        out_if.heard__RDY = 1'b0;
        n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL fulldeq_count: got %0d want 3", count); end
        n_cmp++; if (drop_count !== 8'd4) begin n_fail++; $display("FAIL fulldeq_drop: got %0d want 4", drop_count); end
        n_cmp++; if (ind_if.heard__RDY !== 1'b1) begin n_fail++; $display("FAIL fulldeq_rdy_next: got %b want 1", ind_if.heard__RDY); end
        out_if.heard__RDY = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            n_cmp++; if (out_if.meth !== 32'h20 + 32'(i)) begin n_fail++; $display("FAIL fulldeq_drain[%0d]: got %h want %h", i, out_if.meth, 32'h20 + i); end
            tick();
        end
        out_if.heard__RDY = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL fulldeq_empty: got %0d want 0", count); end
    endtask

    task automatic test_streaming();
        logic [31:0] prev;
        out_if.heard__RDY = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ind_if.heard__ENA = 1'b1;
            ind_if.meth       = i;
            ind_if.v          = ~32'(i);
            if (i > 0) begin
                prev = 32'(i - 1);
                n_cmp++; if (out_if.meth !== prev || out_if.v !== ~prev || out_if.heard__ENA !== 1'b1)
                    begin n_fail++; $display("FAIL stream[%0d]: got ena=%b meth=%h v=%h want meth=%h v=%h", i, out_if.heard__ENA, out_if.meth, out_if.v, prev, ~prev); end
            end
            n_cmp++; if (count > 3'd1) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d want <=1", i, count); end
            tick();
        end
        ind_if.heard__ENA = 1'b0;
        n_cmp++; if (out_if.meth !== 32'd19 || out_if.v !== ~32'd19) begin n_fail++; $display("FAIL stream_last: got meth=%h v=%h want 13/%h", out_if.meth, out_if.v, ~32'd19); end
        tick();
        out_if.heard__RDY = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL stream_end_count: got %0d want 0", count); end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 3; i++) begin
            ind_if.heard__ENA = 1'b1;
            ind_if.meth       = 32'h30 + i;
            ind_if.v          = 32'h300 + i;
            tick();
        end
        n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL rstmid_pre: got %0d want 3", count); end
        rst               = 1'b1;
        ind_if.meth       = 32'h77;
        ind_if.v          = 32'h777;
        out_if.heard__RDY = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d want 0", count); end
        n_cmp++; if (out_if.heard__ENA !== 1'b0) begin n_fail++; $display("FAIL rstmid_ena: got %b want 0", out_if.heard__ENA); end
        n_cmp++; if (ind_if.heard__RDY !== 1'b1) begin n_fail++; $display("FAIL rstmid_rdy: got %b want 1", ind_if.heard__RDY); end
        n_cmp++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL rstmid_drop: got %0d want 0", drop_count); end
        n_cmp++; if (out_if.meth !== 32'h0 || out_if.v !== 32'h0) begin n_fail++; $display("FAIL rstmid_data: got %h/%h want 0/0", out_if.meth, out_if.v); end
        tick();
        n_cmp++; if (out_if.heard__ENA !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale: got %b want 0", out_if.heard__ENA); end
        ind_if.heard__ENA = 1'b1;
        ind_if.meth       = 32'h44;
        ind_if.v          = 32'h444;
        tick();
        ind_if.heard__ENA = 1'b0;
        n_cmp++; if (out_if.meth !== 32'h44 || out_if.v !== 32'h444) begin n_fail++; $display("FAIL rstmid_fresh: got %h/%h want 44/444", out_if.meth, out_if.v); end
        n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL rstmid_fresh_count: got %0d want 1", count); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_deq();
        test_streaming();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/indication_heard_queue.md
# indication_heard_queue

Parametrised successor to the single-method `heard` indication endpoint. It accepts `heard(meth, v)` calls through the usual ENA/RDY method handshake and buffers them in a DEPTH-entry FIFO. It then re-issues them in order on a downstream `out$heard` method port, giving back-pressure instead of an always-ready sink. It sits between a generated indication producer and a slower consumer (e.g. a host response path). It also provides occupancy and refused-call statistics for debug.

## Interface
- `DATA_WIDTH`, 32: width of `meth` and `v` arguments.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `DROP_WIDTH`, 8: width of the saturating refused-call counter.

- `CLK`  input  1  clock; all state updates on rising edge.
- `RST`  input  1  reset, synchronous, active-high.
- `indication$heard__ENA`  input  1  caller invokes heard this cycle.
- `indication$meth`  input  DATA_WIDTH  first argument.
- `indication$v`  input  DATA_WIDTH  second argument.
- `indication$heard__RDY`  output  1  method may fire (FIFO not full).
- `out$heard__ENA`  output  1  downstream call valid (FIFO not empty).
- `out$meth`  output  DATA_WIDTH  head-entry meth.
- `out$v`  output  DATA_WIDTH  head-entry v.
- `out$heard__RDY`  input  1  downstream accepts call this cycle.
- `count`  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `drop_count`  output  DROP_WIDTH  calls refused while full, saturating.

## Operation
- Storage: DEPTH × (2·DATA_WIDTH) register array, write pointer `wp`, read pointer `rp`, occupancy `count`.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH by natural overflow.
- `indication$heard__RDY = (count != DEPTH)`.
- Internal enqueue: `enq = indication$heard__ENA && indication$heard__RDY`.
- On enqueue, {meth, v} is written at `wp` and `wp` increments.
- `out$heard__ENA = (count != 0)`.
- Internal dequeue: `deq = out$heard__ENA && out$heard__RDY`. On dequeue, `rp` increments.
- `out$meth`/`out$v` are driven from entry `rp` when `count != 0`, and are 0 when empty.
- Count update rules:
  - enq only: +1.
  - deq only: −1.
  - both: unchanged.
  - neither: unchanged.
- `indication$heard__ENA` while RDY is low: the call is ignored (no write), and `drop_count` increments, saturating at 2^DROP_WIDTH−1.
- `out$heard__RDY` while empty: ignored; no pointer movement.
- Ordering is strict FIFO. No reordering, no merging of identical calls.

## Timing
- Reset values: `wp`=0, `rp`=0, `count`=0, `drop_count`=0, `indication$heard__RDY`=1, `out$heard__ENA`=0, `out$meth`=0, `out$v`=0. Array contents are not reset.
- Reset dominates: RST high in a cycle with enq and/or deq applies reset only. Queued entries are discarded.
- Latency: a call enqueued in cycle N appears on `out$*` with `out$heard__ENA`=1 in cycle N+1. There is no combinational bypass.
- Full: RDY is low whenever `count==DEPTH`, even if a dequeue occurs the same cycle. RDY rises in the cycle after the dequeue. There is no input→RDY or out$RDY→RDY combinational path.
- Empty: `out$heard__ENA` is low whenever `count==0`, even if an enqueue occurs the same cycle.
- Simultaneous enq+deq with 0<count<DEPTH: both are performed, and count holds.
- Throughput: one call per cycle sustained when neither full nor empty.
- All outputs are functions of registered state only.

## Test plan
- Reset/idle: assert RST 2 cycles then release. Required: RDY=1, out ENA=0, count=0, drop_count=0, out$meth=out$v=0.
- Single call: enqueue meth=0x11, v=0xAA with out RDY=0. Required: next cycle out ENA=1, out$meth=0x11, out$v=0xAA, count=1. Raise out RDY for one cycle; the following cycle ENA=0 and count=0.
- Fill and overflow (DEPTH=4): enqueue meth=1..4 with out RDY=0. Required: RDY=0 with count=4. Three further ENA cycles are refused, drop_count=3, and the FIFO is unchanged. Draining yields meth 1,2,3,4 in order.
- Full with simultaneous dequeue: at count=4, assert in ENA and out RDY in the same cycle. Required: dequeue only, count=3, drop_count+1. RDY=1 the next cycle.
- Streaming/wrap: out RDY=1 continuously and 20 back-to-back calls with meth=i, v=~i. Required: each emerges exactly 1 cycle later in order, count stays ≤1, and the pointers wrap at least 4 times.
- Reset mid-operation: at count=3, assert RST together with in ENA and out RDY. Required: next cycle all reset values hold, and no stale entry appears afterward.
